dumbrv_lsu: RTL and testbench
=============================

DUMBRV_LSU -- requirements
Module: dumbrv_lsu

Interface
REQ-001 SHALL have port clk input 1: clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid_i input 1: work unit presents a memory request.
REQ-004 SHALL have port req_opcode_i input 4: bit3 store(1)/load(0); bit2 zero-extend (loads only); bits1:0 size 00 byte, 01 half, 10 word, 11 treated as word.
REQ-005 SHALL have ports req_addr_i input 32 (byte address), req_data_i input 32 (store data), req_dreg_i input 4 (load destination register).
REQ-006 SHALL have port req_accept_o output 1: request taken this cycle.
REQ-007 SHALL have ports wb_dreg_o output 4 and wb_data_o output 32: load writeback to register file; wb_dreg_o 0 means no write.
REQ-008 SHALL have port wb_done_i input 1: register file committed the writeback.
REQ-009 SHALL have port load_dreg_o output 4: destination of the in-flight load, 0 if none.
REQ-010 SHALL have memory ports mem_req_o output 1, mem_we_o output 1, mem_addr_o output 16, mem_wdata_o output 8, mem_rdata_i input 8, mem_ack_i input 1.

Function
REQ-011 SHALL implement states IDLE, XFER, WB; one request outstanding at most.
REQ-012 req_accept_o SHALL equal req_valid_i AND state==IDLE (combinational); on accept, latch opcode, addr[15:0], data and dreg, and go to XFER.
REQ-013 SHALL transfer size bytes (1/2/4) byte-serially, little-endian; byte i at addr+i, addresses wrapping modulo 2^16.
REQ-014 In XFER mem_req_o SHALL be 1, with mem_addr_o/mem_we_o/mem_wdata_o stable until a cycle where mem_ack_i=1.
REQ-015 On each ack the 2-bit byte counter SHALL advance; loads capture mem_rdata_i into byte lane i; back-to-back acks SHALL give one byte per cycle.
REQ-016 mem_we_o SHALL be opcode bit3; mem_wdata_o SHALL be req_data byte i.
REQ-017 After last byte: store or load with dreg 0 SHALL return to IDLE; other loads SHALL go to WB.
REQ-018 Load data SHALL be sign-extended from bit 7/15 unless bit2 set (zero-extend); word loads unmodified.
REQ-019 In WB wb_dreg_o SHALL be latched dreg and wb_data_o the extended value; wb_dreg_o SHALL be 0 in all other states.
REQ-020 WB SHALL hold until wb_done_i=1, then go to IDLE; wb_done_i outside WB SHALL be ignored.
REQ-021 load_dreg_o SHALL be latched dreg from accept edge through the WB exit edge for loads; 0 for stores and when idle.
REQ-022 Latency: accept on edge E; mem_req_o high from cycle after E; with zero-wait acks, word load enters WB 4 cycles after E.
REQ-023 mem_ack_i outside XFER SHALL be ignored.

Reset
REQ-024 On rst_n low (any state, including mid-transfer) SHALL go to IDLE immediately; mem_req_o, mem_we_o, req_accept_o state qualifier, wb_dreg_o, load_dreg_o SHALL be 0; byte counter 0; partial transfer abandoned.
REQ-025 Datapath registers (addr, data, captured bytes) need no reset; mem_addr_o/mem_wdata_o don't-care while mem_req_o=0.

Configuration
REQ-026 Macro DUMBRV_LSU_MISALIGN_EN: defined, misaligned half/word accesses SHALL proceed byte-wise from the given address; undefined, address SHALL be forced aligned (bit0 cleared for half, bits1:0 cleared for word) at accept.

Verification
REQ-027 Store word 0xA1B2C3D4 to 0x0100, zero-wait ack -> bytes D4,C3,B2,A1 at 0x0100..0x0103 in 4 consecutive cycles, no writeback, IDLE after.
REQ-028 Load byte signed dreg 5 from 0x0010 returning 0x80 -> wb_dreg_o 5, wb_data_o 0xFFFFFF80; zero-extend variant -> 0x00000080; load_dreg_o 5 until wb_done_i.
REQ-029 Load half from 0xFFFF with misalign enabled -> addresses 0xFFFF then 0x0000; disabled -> 0xFFFE, 0xFFFF.
REQ-030 Ack delayed 3 cycles per byte -> mem_addr_o/mem_wdata_o stable throughout; req_accept_o stays 0 for second req_valid_i until IDLE.
REQ-031 Load dreg 0 -> memory access performed, no WB state, load_dreg_o stays 0.
REQ-032 rst_n low during byte 2 of word store -> mem_req_o 0 immediately; after release, new request accepted on first valid cycle.

Source files
------------

// File: rtl/dumbrv_lsu_if.sv
// Request, writeback and byte-wide memory bus bundle for dumbrv_lsu.
// The LSU uses the master view; the surrounding core, register file and memory use the slave view.
interface dumbrv_lsu_if;
  logic        req_valid_i;
  logic [3:0]  req_opcode_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_dreg_i;
  logic        req_accept_o;

  logic [3:0]  wb_dreg_o;
  logic [31:0] wb_data_o;
  logic        wb_done_i;
  logic [3:0]  load_dreg_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    input  req_valid_i, req_opcode_i, req_addr_i, req_data_i, req_dreg_i,
    output req_accept_o,
    output wb_dreg_o, wb_data_o,
    input  wb_done_i,
    output load_dreg_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    output req_valid_i, req_opcode_i, req_addr_i, req_data_i, req_dreg_i,
    input  req_accept_o,
    input  wb_dreg_o, wb_data_o,
    output wb_done_i,
    input  load_dreg_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/dumbrv_lsu.sv
// Byte-serial load/store unit: one request at a time, little-endian over an 8-bit memory bus.
// Define DUMBRV_LSU_MISALIGN_EN to let misaligned half/word accesses start at the given byte.
module dumbrv_lsu (
  input logic          clk,
  input logic          rst_n,
  dumbrv_lsu_if.master bus
);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;

  logic [3:0]  op_reg;
  logic [15:0] addr_reg;
  logic [31:0] data_reg;
  logic [3:0]  dreg_reg;
  logic [7:0]  lane_reg [4];

  logic        accept;
  logic [15:0] aligned_addr;
  logic [1:0]  last_idx;
  logic [31:0] ext_data;

  assign accept = bus.req_valid_i && (state_reg == IDLE);

  always_comb begin
    aligned_addr = bus.req_addr_i[15:0];
`ifndef DUMBRV_LSU_MISALIGN_EN
    case (bus.req_opcode_i[1:0])
      2'b00:   aligned_addr = bus.req_addr_i[15:0];
      2'b01:   aligned_addr = {bus.req_addr_i[15:1], 1'b0};
      default: aligned_addr = {bus.req_addr_i[15:2], 2'b00};
    endcase
`endif
  end

  always_comb begin
    case (op_reg[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = XFER;
          cnt_next   = 2'd0;
        end
      end
      XFER: begin
        if (bus.mem_ack_i) begin
          if (cnt_reg == last_idx) begin
            cnt_next   = 2'd0;
            // Stores and loads to x0 have nothing to write back.
            state_next = (op_reg[3] || dreg_reg == 4'd0) ? IDLE : WB;
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end
      WB: begin
        if (bus.wb_done_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request datapath needs no reset; it is only observed once a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg   <= bus.req_opcode_i;
      addr_reg <= aligned_addr;
      data_reg <= bus.req_data_i;
      dreg_reg <= bus.req_dreg_i;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (state_reg == XFER && bus.mem_ack_i && !op_reg[3] && cnt_reg == 2'(gi))
          lane_reg[gi] <= bus.mem_rdata_i;
      end
    end
  endgenerate

  always_comb begin
    case (op_reg[1:0])
      2'b00:   ext_data = op_reg[2] ? {24'd0, lane_reg[0]}
                                    : {{24{lane_reg[0][7]}}, lane_reg[0]};
      2'b01:   ext_data = op_reg[2] ? {16'd0, lane_reg[1], lane_reg[0]}
                                    : {{16{lane_reg[1][7]}}, lane_reg[1], lane_reg[0]};
      default: ext_data = {lane_reg[3], lane_reg[2], lane_reg[1], lane_reg[0]};
    endcase
  end

  assign bus.req_accept_o = accept;
  assign bus.mem_req_o    = (state_reg == XFER);
  assign bus.mem_we_o     = (state_reg == XFER) && op_reg[3];
  assign bus.mem_addr_o   = addr_reg + {14'd0, cnt_reg};
  assign bus.mem_wdata_o  = data_reg[{cnt_reg, 3'b000} +: 8];
  assign bus.wb_dreg_o    = (state_reg == WB) ? dreg_reg : 4'd0;
  assign bus.wb_data_o    = ext_data;
  assign bus.load_dreg_o  = (state_reg != IDLE && !op_reg[3]) ? dreg_reg : 4'd0;

endmodule

// File: tb/tb_dumbrv_lsu.sv
// Directed self-checking bench for dumbrv_lsu; expected bus traffic and writeback values are hand-computed.
module tb_dumbrv_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dumbrv_lsu_if bus ();

  dumbrv_lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic do_accept(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] dreg);
    bus.req_opcode_i = op;
    bus.req_addr_i   = addr;
    bus.req_data_i   = data;
    bus.req_dreg_i   = dreg;
    bus.req_valid_i  = 1'b1;
    #1;
    chk({tag, " accept"}, 32'(bus.req_accept_o), 32'd1);
    chk({tag, " idle_req"}, 32'(bus.mem_req_o), 32'd0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk({tag, " load_dreg"}, 32'(bus.load_dreg_o), op[3] ? 32'd0 : 32'(dreg));
    $display("accept %s op=%h addr=%h data=%h dreg=%0d", tag, op, addr, data, dreg);
  endtask

  // One byte of transfer; the bus must hold steady for every wait cycle before the ack.
  task automatic xfer_byte(input string tag, input logic [15:0] exp_addr, input logic exp_we,
                           input logic [7:0] exp_wdata, input logic [7:0] rdata, input int waits);
    for (int w = 0; w <= waits; w++) begin
      chk({tag, " mem_req"}, 32'(bus.mem_req_o), 32'd1);
      chk({tag, " mem_addr"}, 32'(bus.mem_addr_o), 32'(exp_addr));
      chk({tag, " mem_we"}, 32'(bus.mem_we_o), 32'(exp_we));
      if (exp_we) chk({tag, " mem_wdata"}, 32'(bus.mem_wdata_o), 32'(exp_wdata));
      chk({tag, " accept_busy"}, 32'(bus.req_accept_o), 32'd0);
      chk({tag, " wb_dreg_busy"}, 32'(bus.wb_dreg_o), 32'd0);
      if (w == waits) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rdata;
      end
      @(posedge clk); #1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 8'hEE;
    end
    $display("byte %s addr=%h we=%0d wdata=%h rdata=%h waits=%0d", tag, exp_addr, exp_we, exp_wdata, rdata, waits);
  endtask

  task automatic wb_check(input string tag, input logic [3:0] dreg, input logic [31:0] data);
    chk({tag, " wb_dreg"}, 32'(bus.wb_dreg_o), 32'(dreg));
    chk({tag, " wb_data"}, bus.wb_data_o, data);
    chk({tag, " wb_load_dreg"}, 32'(bus.load_dreg_o), 32'(dreg));
    chk({tag, " wb_mem_req"}, 32'(bus.mem_req_o), 32'd0);
    bus.wb_done_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_done_i = 1'b0;
    chk({tag, " post_wb_dreg"}, 32'(bus.wb_dreg_o), 32'd0);
    chk({tag, " post_load_dreg"}, 32'(bus.load_dreg_o), 32'd0);
    $display("writeback %s dreg=%0d data=%h", tag, dreg, data);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, " idle_mem_req"}, 32'(bus.mem_req_o), 32'd0);
    chk({tag, " idle_wb_dreg"}, 32'(bus.wb_dreg_o), 32'd0);
    chk({tag, " idle_load_dreg"}, 32'(bus.load_dreg_o), 32'd0);
  endtask

  logic [15:0] mis_a0, mis_a1;

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_opcode_i = 4'h0;
    bus.req_addr_i   = 32'h0;
    bus.req_data_i   = 32'h0;
    bus.req_dreg_i   = 4'h0;
    bus.wb_done_i    = 1'b0;
    bus.mem_rdata_i  = 8'h00;
    bus.mem_ack_i    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    idle_check("reset");
    chk("reset mem_we", 32'(bus.mem_we_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray ack and done while idle are ignored
    bus.mem_ack_i = 1'b1;
    bus.wb_done_i = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    bus.wb_done_i = 1'b0;
    idle_check("stray_ack");

    // Store word, zero-wait acks
    do_accept("sw", 4'b1010, 32'h0000_0100, 32'hA1B2_C3D4, 4'd9);
    xfer_byte("sw0", 16'h0100, 1'b1, 8'hD4, 8'h00, 0);
    xfer_byte("sw1", 16'h0101, 1'b1, 8'hC3, 8'h00, 0);
    xfer_byte("sw2", 16'h0102, 1'b1, 8'hB2, 8'h00, 0);
    xfer_byte("sw3", 16'h0103, 1'b1, 8'hA1, 8'h00, 0);
    idle_check("sw_done");

    // Signed byte load, held in writeback for a cycle
    do_accept("lb", 4'b0000, 32'h0000_0010, 32'h0, 4'd5);
    xfer_byte("lb0", 16'h0010, 1'b0, 8'h00, 8'h80, 0);
    bus.mem_ack_i   = 1'b1;
    bus.req_valid_i = 1'b1;
    #1;
    chk("lb wb_accept", 32'(bus.req_accept_o), 32'd0);
    @(posedge clk); #1;
    bus.mem_ack_i   = 1'b0;
    bus.req_valid_i = 1'b0;
    wb_check("lb", 4'd5, 32'hFFFF_FF80);

    // Zero-extended byte load
    do_accept("lbu", 4'b0100, 32'h0000_0010, 32'h0, 4'd5);
    xfer_byte("lbu0", 16'h0010, 1'b0, 8'h00, 8'h80, 0);
    wb_check("lbu", 4'd5, 32'h0000_0080);

    // Signed and unsigned half loads
    do_accept("lh", 4'b0001, 32'h0000_0F02, 32'h0, 4'd6);
    xfer_byte("lh0", 16'h0F02, 1'b0, 8'h00, 8'h34, 0);
    xfer_byte("lh1", 16'h0F03, 1'b0, 8'h00, 8'h92, 0);
    wb_check("lh", 4'd6, 32'hFFFF_9234);
    do_accept("lhu", 4'b0101, 32'h0000_0F02, 32'h0, 4'd6);
    xfer_byte("lhu0", 16'h0F02, 1'b0, 8'h00, 8'hCD, 0);
    xfer_byte("lhu1", 16'h0F03, 1'b0, 8'h00, 8'hAB, 0);
    wb_check("lhu", 4'd6, 32'h0000_ABCD);

    // Word load enters writeback four cycles after accept; size 11 behaves as word
    do_accept("lw", 4'b0111, 32'hDEAD_0200, 32'h0, 4'd3);
    xfer_byte("lw0", 16'h0200, 1'b0, 8'h00, 8'h11, 0);
    xfer_byte("lw1", 16'h0201, 1'b0, 8'h00, 8'h22, 0);
    xfer_byte("lw2", 16'h0202, 1'b0, 8'h00, 8'h33, 0);
    xfer_byte("lw3", 16'h0203, 1'b0, 8'h00, 8'hC4, 0);
    wb_check("lw", 4'd3, 32'hC433_2211);

    // Half load at 0xFFFF: wraps when misalignment allowed, else aligned down
`ifdef DUMBRV_LSU_MISALIGN_EN
    mis_a0 = 16'hFFFF;
    mis_a1 = 16'h0000;
`else
    mis_a0 = 16'hFFFE;
    mis_a1 = 16'hFFFF;
`endif
    do_accept("lhmis", 4'b0001, 32'h0000_FFFF, 32'h0, 4'd7);
    xfer_byte("lhmis0", mis_a0, 1'b0, 8'h00, 8'h01, 0);
    xfer_byte("lhmis1", mis_a1, 1'b0, 8'h00, 8'h80, 0);
    wb_check("lhmis", 4'd7, 32'hFFFF_8001);

    // Slow acks with a competing request held until idle
    do_accept("shslow", 4'b1001, 32'h0000_0020, 32'h1234_BEEF, 4'd0);
    bus.req_opcode_i = 4'b1000;
    bus.req_addr_i   = 32'h0000_0030;
    bus.req_data_i   = 32'h0000_0055;
    bus.req_dreg_i   = 4'd0;
    bus.req_valid_i  = 1'b1;
    #1;
    xfer_byte("shslow0", 16'h0020, 1'b1, 8'hEF, 8'h00, 3);
    xfer_byte("shslow1", 16'h0021, 1'b1, 8'hBE, 8'h00, 3);
    bus.req_valid_i = 1'b0;
    do_accept("sb", 4'b1000, 32'h0000_0030, 32'h0000_0055, 4'd0);
    xfer_byte("sb0", 16'h0030, 1'b1, 8'h55, 8'h00, 0);
    idle_check("sb_done");

    // Load to x0: bus traffic only, no writeback
    do_accept("lwx0", 4'b0010, 32'h0000_0040, 32'h0, 4'd0);
    xfer_byte("lwx0_0", 16'h0040, 1'b0, 8'h00, 8'hAA, 0);
    xfer_byte("lwx0_1", 16'h0041, 1'b0, 8'h00, 8'hBB, 0);
    xfer_byte("lwx0_2", 16'h0042, 1'b0, 8'h00, 8'hCC, 0);
    xfer_byte("lwx0_3", 16'h0043, 1'b0, 8'h00, 8'hDD, 0);
    idle_check("lwx0_done");

    // Reset in the middle of a word store
    do_accept("swrst", 4'b1010, 32'h0000_0050, 32'h0102_0304, 4'd0);
    xfer_byte("swrst0", 16'h0050, 1'b1, 8'h04, 8'h00, 0);
    xfer_byte("swrst1", 16'h0051, 1'b1, 8'h03, 8'h00, 0);
    chk("swrst byte2_addr", 32'(bus.mem_addr_o), 32'h0000_0052);
    rst_n = 1'b0;
    #1;
    idle_check("swrst async");
    chk("swrst mem_we", 32'(bus.mem_we_o), 32'd0);
    $display("reset asserted mid-transfer");
    @(negedge clk);
    rst_n = 1'b1;
    do_accept("lbpost", 4'b0000, 32'h0000_0060, 32'h0, 4'd2);
    xfer_byte("lbpost0", 16'h0060, 1'b0, 8'h00, 8'h7F, 0);
    wb_check("lbpost", 4'd2, 32'h0000_007F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
